// File: rtl/triumph_pkg.sv
// triumph_pkg: shared state encoding, load-size codes and timeout default for the WB stage
package triumph_pkg;
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_COMMIT    = 2'd2
    } wb_state_e;
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam int TIMEOUT_DEFAULT = 255;
    function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == LS_BYTE ? 1'b0 : size == LS_HALF ? off[0] : off != 2'b00;
    endfunction
endpackage

// File: rtl/triumph_wb_stage_if.sv
// triumph_wb_if: EX offer, LSU response and register-file write bundle of the WB stage
interface triumph_wb_if;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [1:0]  ex_load_size_i;
    logic        ex_load_unsigned_i;
    logic [1:0]  ex_addr_lsb_i;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic        data_valid_wb_o;
    logic [4:0]  rd_addr_wb_o;
    logic [31:0] rd_data_wb_o;
    logic        load_err_o;
    modport slave (
        input  ex_valid_i, ex_rd_addr_i, ex_result_i, ex_is_load_i, ex_load_size_i,
               ex_load_unsigned_i, ex_addr_lsb_i, lsu_rvalid_i, lsu_rdata_i,
        output ex_ready_o, data_valid_wb_o, rd_addr_wb_o, rd_data_wb_o, load_err_o
    );
    modport master (
        output ex_valid_i, ex_rd_addr_i, ex_result_i, ex_is_load_i, ex_load_size_i,
               ex_load_unsigned_i, ex_addr_lsb_i, lsu_rvalid_i, lsu_rdata_i,
        input  ex_ready_o, data_valid_wb_o, rd_addr_wb_o, rd_data_wb_o, load_err_o
    );
endinterface

// File: rtl/triumph_load_align.sv
// triumph_load_align: selects the byte/half at the load offset and sign- or zero-extends it
module triumph_load_align
    import triumph_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = 8'(rdata_i >> {offset_i, 3'b000});
        h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = size_i == LS_BYTE ? {{24{b[7] & ~unsigned_i}}, b}
               : size_i == LS_HALF ? {{16{h[15] & ~unsigned_i}}, h}
               : rdata_i;
    end
endmodule

// File: rtl/triumph_wb_stage.sv
// triumph_wb_stage: write-back stage retiring ALU results and aligned loads to the register file
// Optional EX bypass outputs (fwd_*) exist only when TRIUMPH_WB_FWD_EN is defined.
module triumph_wb_stage
    import triumph_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    triumph_wb_if.slave wb
`ifdef TRIUMPH_WB_FWD_EN
    ,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    wb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [4:0]  ld_rd_q;
    logic [1:0]  ld_size_q, ld_off_q;
    logic        ld_uns_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        err_q;
    logic        transfer, misaligned, timeout;
    logic [31:0] ld_data;

    assign transfer   = wb.ex_valid_i & wb.ex_ready_o;
    assign misaligned = load_misaligned(wb.ex_load_size_i, wb.ex_addr_lsb_i);
    assign timeout    = 32'(cnt_q) == TIMEOUT_CYCLES - 1;

    triumph_load_align u_align (
        .rdata_i   (wb.lsu_rdata_i),
        .size_i    (ld_size_q),
        .unsigned_i(ld_uns_q),
        .offset_i  (ld_off_q),
        .data_o    (ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = S_IDLE;
        if (transfer)
            state_d = !wb.ex_is_load_i ? S_COMMIT : misaligned ? S_IDLE : S_WAIT_LOAD;
        else if (state_q == S_WAIT_LOAD)
            state_d = wb.lsu_rvalid_i ? S_COMMIT : timeout ? S_IDLE : S_WAIT_LOAD;
    end

    always_comb begin
        wb.ex_ready_o      = ~rst_i & (state_q != S_WAIT_LOAD);
        wb.data_valid_wb_o = state_q == S_COMMIT && wb_addr_q != 5'd0;
        wb.rd_addr_wb_o    = wb_addr_q;
        wb.rd_data_wb_o    = wb_data_q;
        wb.load_err_o      = err_q;
`ifdef TRIUMPH_WB_FWD_EN
        fwd_valid_o        = wb.data_valid_wb_o;
        fwd_addr_o         = wb_addr_q;
        fwd_data_o         = wb_data_q;
`endif
    end

    // Write port registers only change on a new retirement, so they hold while valid is high
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_size_q <= '0;
            ld_off_q  <= '0;
            ld_uns_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (transfer) begin
                cnt_q <= '0;
                if (!wb.ex_is_load_i) begin
                    wb_addr_q <= wb.ex_rd_addr_i;
                    wb_data_q <= wb.ex_result_i;
                end else begin
                    ld_rd_q   <= wb.ex_rd_addr_i;
                    ld_size_q <= wb.ex_load_size_i;
                    ld_off_q  <= wb.ex_addr_lsb_i;
                    ld_uns_q  <= wb.ex_load_unsigned_i;
                    err_q     <= misaligned;
                end
            end else if (state_q == S_WAIT_LOAD) begin
                if (wb.lsu_rvalid_i) begin
                    wb_addr_q <= ld_rd_q;
                    wb_data_q <= ld_data;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    err_q <= timeout;
                end
            end
        end
endmodule
